// File: rtl/overlap_save_framer.sv
// Overlap-save framer: builds NFFT-sample frames from the previous HALF samples
// followed by HALF new samples, emitted with first/last/idx framing.
module overlap_save_framer #(
  parameter int W    = 16,
  parameter int NFFT = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic signed [W-1:0]     i_x_re,
  input  logic signed [W-1:0]     i_x_im,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic signed [W-1:0]     o_y_re,
  output logic signed [W-1:0]     o_y_im,
  output logic                    o_first,
  output logic                    o_last,
  output logic [$clog2(NFFT)-1:0] o_idx
);

  localparam int HALF  = NFFT / 2;
  localparam int IDX_W = $clog2(NFFT);
  localparam int HW    = $clog2(HALF);

  typedef enum logic {FILL, EMIT} state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  bank_q, bank_d;
  logic                  primed_q, primed_d;
  logic                  valid_q, valid_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic signed [W-1:0]   y_re_q, y_re_d;
  logic signed [W-1:0]   y_im_q, y_im_d;

  // Both banks live in one array; the top address bit selects the bank.
  logic signed [W-1:0]   mem_re_q [NFFT];
  logic signed [W-1:0]   mem_im_q [NFFT];

  logic                  wr_en;
  logic [IDX_W-1:0]      wr_addr;
  logic                  rd_old;
  logic [IDX_W-1:0]      rd_addr;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    bank_d   = bank_q;
    primed_d = primed_q;
    valid_d  = 1'b0;
    first_d  = 1'b0;
    last_d   = 1'b0;
    idx_d    = idx_q;
    y_re_d   = y_re_q;
    y_im_d   = y_im_q;
    wr_en    = 1'b0;
    wr_addr  = {bank_q, wr_cnt_q};
    rd_old   = ~rd_cnt_q[IDX_W-1];
    rd_addr  = {bank_q ^ rd_old, rd_cnt_q[HW-1:0]};

    case (state_q)
      FILL: begin
        if (i_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == HW'(HALF - 1)) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = EMIT;
          end else begin
            wr_cnt_d = wr_cnt_q + HW'(1);
          end
        end
      end
      EMIT: begin
        valid_d = 1'b1;
        idx_d   = rd_cnt_q;
        first_d = (rd_cnt_q == '0);
        last_d  = (rd_cnt_q == IDX_W'(NFFT - 1));
        // Until one full frame has gone by, the old half is defined as zeros.
        if (rd_old && !primed_q) begin
          y_re_d = '0;
          y_im_d = '0;
        end else begin
          y_re_d = mem_re_q[rd_addr];
          y_im_d = mem_im_q[rd_addr];
        end
        if (last_d) begin
          bank_d   = ~bank_q;
          primed_d = 1'b1;
          rd_cnt_d = '0;
          state_d  = FILL;
        end else begin
          rd_cnt_d = rd_cnt_q + IDX_W'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_re_q[wr_addr] <= i_x_re;
      mem_im_q[wr_addr] <= i_x_im;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      bank_q   <= 1'b0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      y_re_q   <= '0;
      y_im_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      bank_q   <= bank_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      y_re_q   <= y_re_d;
      y_im_q   <= y_im_d;
    end
  end

  assign o_ready = (state_q == FILL);
  assign o_valid = valid_q;
  assign o_first = first_q;
  assign o_last  = last_q;
  assign o_idx   = idx_q;
  assign o_y_re  = y_re_q;
  assign o_y_im  = y_im_q;

endmodule

// File: tb/tb_overlap_save_framer.sv
// Directed bench for overlap_save_framer (W=16, NFFT=32): table of bursts plus
// hand-written reset-mid-frame and continuous-valid sequences.
module tb_overlap_save_framer;

  localparam int W    = 16;
  localparam int NFFT = 32;
  localparam int HALF = 16;

  logic                clk;
  logic                rst_n;
  logic                i_valid;
  logic signed [W-1:0] i_x_re;
  logic signed [W-1:0] i_x_im;
  logic                o_ready;
  logic                o_valid;
  logic signed [W-1:0] o_y_re;
  logic signed [W-1:0] o_y_im;
  logic                o_first;
  logic                o_last;
  logic [4:0]          o_idx;

  int checks = 0;
  int errors = 0;

  overlap_save_framer #(.W(W), .NFFT(NFFT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .i_x_re  (i_x_re),
    .i_x_im  (i_x_im),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_y_re  (o_y_re),
    .o_y_im  (o_y_im),
    .o_first (o_first),
    .o_last  (o_last),
    .o_idx   (o_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int base;
    int gap;
    bit old_zero;
    int old_base;
    bit junk;
  } burst_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packs {valid, first, last, ready, idx, re, im} for a single comparison.
  function automatic logic [63:0] pack(input logic v, input logic f, input logic l,
                                       input logic r, input logic [4:0] idx,
                                       input logic [15:0] re, input logic [15:0] im);
    return {23'd0, v, f, l, r, idx, re, im};
  endfunction

  function automatic logic [63:0] dut_vec();
    return pack(o_valid, o_first, o_last, o_ready, o_idx, o_y_re, o_y_im);
  endfunction

  task automatic feed_burst(input int base, input int gap);
    logic [15:0] re;
    for (int k = 0; k < HALF; k++) begin
      repeat (gap) begin
        i_valid = 1'b0;
        @(negedge clk);
        chk("fill_idle", {61'd0, o_valid, o_first, o_last}, 64'd0);
      end
      re      = 16'(base + k);
      i_valid = 1'b1;
      i_x_re  = re;
      i_x_im  = -re;
      chk("fill_ready", {63'd0, o_ready}, 64'd1);
      @(negedge clk);
      chk("fill_novalid", {61'd0, o_valid, o_first, o_last}, 64'd0);
    end
    i_valid = 1'b0;
  endtask

  task automatic check_frame(input int new_base, input int old_base, input bit old_zero,
                             input int n, input bit junk);
    logic [15:0] re;
    i_valid = junk;
    i_x_re  = 16'sh7fff;
    i_x_im  = 16'sh8000;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i < HALF) re = old_zero ? 16'd0 : 16'(old_base + i);
      else          re = 16'(new_base + i - HALF);
      chk($sformatf("frame%0d_idx%0d", new_base, i), dut_vec(),
          pack(1'b1, i == 0, i == NFFT - 1, i == NFFT - 1, 5'(i), re, -re));
      i_valid = junk && (i != NFFT - 1);
    end
    i_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, dut_vec(), pack(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 16'd0, 16'd0));
  endtask

  initial begin
    burst_t vecs[6];
    int v, frames, eidx, lowcnt;
    logic acc;
    logic [15:0] re;

    vecs[0] = '{base: 0,      gap: 0, old_zero: 1'b1, old_base: 0,     junk: 1'b0};
    vecs[1] = '{base: 100,    gap: 0, old_zero: 1'b0, old_base: 0,     junk: 1'b0};
    vecs[2] = '{base: 200,    gap: 0, old_zero: 1'b0, old_base: 100,   junk: 1'b1};
    vecs[3] = '{base: 300,    gap: 7, old_zero: 1'b0, old_base: 200,   junk: 1'b0};
    vecs[4] = '{base: 32752,  gap: 0, old_zero: 1'b0, old_base: 300,   junk: 1'b1};
    vecs[5] = '{base: -32768, gap: 3, old_zero: 1'b0, old_base: 32752, junk: 1'b0};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_x_re  = '0;
    i_x_im  = '0;
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;

    // Gapless bursts offer sample 0 in the o_last cycle of the previous frame.
    for (int t = 0; t < 6; t++) begin
      feed_burst(vecs[t].base, vecs[t].gap);
      check_frame(vecs[t].base, vecs[t].old_base, vecs[t].old_zero, NFFT, vecs[t].junk);
    end

    // Reset mid-frame: asynchronous clear, then the next frame restarts unprimed.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    feed_burst(10, 0);
    check_frame(10, 0, 1'b1, NFFT, 1'b0);
    feed_burst(50, 0);
    check_frame(50, 10, 1'b0, 11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_mid_emit");
    @(negedge clk);
    check_reset_outputs("reset_mid_emit_held");
    rst_n = 1'b1;
    feed_burst(500, 1);
    check_frame(500, 0, 1'b1, NFFT, 1'b0);

    // Continuous valid: value increments on every accepting edge.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    v       = 1000;
    frames  = 0;
    eidx    = 0;
    lowcnt  = 0;
    i_valid = 1'b1;
    i_x_re  = 16'(v);
    i_x_im  = -16'(v);
    for (int cyc = 0; cyc < 400 && frames < 5; cyc++) begin
      acc = o_ready;
      @(negedge clk);
      if (o_valid) begin
        if (eidx >= HALF)  re = 16'(1000 + HALF * frames + eidx - HALF);
        else if (frames == 0) re = 16'd0;
        else               re = 16'(1000 + HALF * (frames - 1) + eidx);
        chk($sformatf("cont_f%0d_idx%0d", frames, eidx),
            {24'd0, o_valid, o_first, o_last, o_idx, o_y_re, o_y_im},
            {24'd0, 1'b1, eidx == 0, eidx == NFFT - 1, 5'(eidx), re, -re});
        if (!o_ready) lowcnt++;
        if (o_last) begin
          chk("cont_ready_low_while_valid", 64'(lowcnt), 64'd31);
          frames++;
          lowcnt = 0;
          eidx   = 0;
        end else begin
          eidx++;
        end
      end
      if (acc) begin
        v++;
        i_x_re = 16'(v);
        i_x_im = -16'(v);
      end
    end
    i_valid = 1'b0;
    chk("cont_frames_seen", 64'(frames), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
